// File: rtl/counter_sweep_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_sweep_controller_pkg
// Brief    : State encodings and direction constants for the sweep controller.
// Revision : 1.0 - initial release
// ============================================================================
package counter_sweep_controller_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/counter_sweep_controller_core.sv
`default_nettype none
// ============================================================================
// Module   : updown_count_core
// Brief    : Loadable modulo-2^W up/down counter; load has priority over en.
// Revision : 1.0 - initial release
// ============================================================================
module updown_count_core
    import counter_sweep_controller_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] din,
    input  logic         dir,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] C_ONE = W'(1);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= din;
        end else if (en) begin
            case (dir)
                DIR_UP:   r_count <= r_count + C_ONE;
                DIR_DOWN: r_count <= r_count - C_ONE;
                default:  r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/counter_sweep_controller.sv
`default_nettype none
// ============================================================================
// Module   : counter_sweep_controller
// Brief    : Runs programmed (optionally bouncing) count sweeps on an up/down core.
// Revision : 1.0 - initial release
// ============================================================================
module counter_sweep_controller
    import counter_sweep_controller_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] start_val,
    input  logic [W-1:0] end_val,
    input  logic         dir,
    input  logic         bounce,
    input  logic         hold,
    input  logic         abort,
    output logic         busy,
    output logic         done,
    output logic         phase,
    output logic [W-1:0] count
);

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_start;
    logic [W-1:0] r_end;
    logic         r_dir;
    logic         r_bounce;
    logic         r_phase;
    logic [W-1:0] w_target;
    logic         w_match;
    logic         w_turn;
    logic         w_load;
    logic         w_en;

    assign w_target = r_phase ? r_start : r_end;
    assign w_match  = (count == w_target);
    // A match on the outbound leg of a bounce sweep reverses instead of finishing.
    assign w_turn   = w_match && r_bounce && !r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_LOAD;
            ST_LOAD: w_next = abort ? ST_IDLE : ST_RUN;
            ST_RUN: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_match && !w_turn) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_en   = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_LOAD: begin
                busy   = 1'b1;
                w_load = !abort;
            end
            ST_RUN: begin
                busy = 1'b1;
                w_en = !abort && !w_match && !hold;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start  <= '0;
            r_end    <= '0;
            r_dir    <= 1'b0;
            r_bounce <= 1'b0;
            r_phase  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_start  <= start_val;
                r_end    <= end_val;
                r_dir    <= dir;
                r_bounce <= bounce;
            end
            if (r_state == ST_DONE || ((r_state == ST_LOAD || r_state == ST_RUN) && abort)) begin
                r_phase <= 1'b0;
            end else if (r_state == ST_RUN && w_turn) begin
                r_phase <= 1'b1;
                r_dir   <= ~r_dir;
            end
        end
    end

    assign phase = r_phase;

    updown_count_core #(
        .W(W)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .en    (w_en),
        .din   (r_start),
        .dir   (r_dir),
        .count (count)
    );

endmodule
`default_nettype wire
